// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: two-client box plotter with clear-screen sweep.
// Ports: iClock/iReset, iClear, iReq[1:0], per-client X/Y/colour in;
//   oX/oY/oColour/oPlot pixel out, oDone/oClearDone/oBusy status.
module vga_plot_arbiter #(
  parameter logic [7:0] X_BOXSIZE       = 8'd4,
  parameter logic [6:0] Y_BOXSIZE       = 7'd4,
  parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iClear,
  input  logic [1:0] iReq,
  input  logic [7:0] iX0,
  input  logic [7:0] iX1,
  input  logic [6:0] iY0,
  input  logic [6:0] iY1,
  input  logic [2:0] iColour0,
  input  logic [2:0] iColour1,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic [1:0] oDone,
  output logic       oClearDone,
  output logic       oBusy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_BOX
  } state_e;

  localparam int unsigned BOXN =
    int'(X_BOXSIZE) * int'(Y_BOXSIZE);
  localparam int unsigned PW =
    (BOXN > 1) ? $clog2(BOXN) : 1;
  localparam logic [PW-1:0] PLAST = PW'(BOXN - 1);
  localparam logic [7:0] XLAST = X_SCREEN_PIXELS - 8'd1;
  localparam logic [6:0] YLAST = Y_SCREEN_PIXELS - 7'd1;

  state_e        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [7:0]    cx_q, cx_d;
  logic [6:0]    cy_q, cy_d;
  logic [7:0]    bx_q, bx_d;
  logic [6:0]    by_q, by_d;
  logic [2:0]    bc_q, bc_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;

  logic       gnt_cli;
  logic [7:0] xoff;
  logic [6:0] yoff;
  logic [7:0] bpx;
  logic [6:0] bpy;
  logic       box_last;
  logic       clr_last;

  // On a tie the client not served last wins.
  assign gnt_cli = (iReq == 2'b11) ? ~last_q : iReq[1];

  // Row-major walk of the box from a single pixel index.
  assign xoff = 8'(32'(pix_q) % 32'(X_BOXSIZE));
  assign yoff = 7'(32'(pix_q) / 32'(X_BOXSIZE));
  assign bpx  = bx_q + xoff;
  assign bpy  = by_q + yoff;

  assign box_last = (pix_q == PLAST);
  assign clr_last = (cx_q == XLAST) && (cy_q == YLAST);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bc_d    = bc_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (iClear) begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (iReq != 2'b00) begin
          state_d = S_BOX;
          pix_d   = '0;
          owner_d = gnt_cli;
          last_d  = gnt_cli;
          if (gnt_cli) begin
            bx_d = iX1;
            by_d = iY1;
            bc_d = iColour1;
          end else begin
            bx_d = iX0;
            by_d = iY0;
            bc_d = iColour0;
          end
        end
      end
      S_CLEAR: begin
        if (clr_last) begin
          state_d = S_IDLE;
          cx_d    = '0;
          cy_d    = '0;
        end else if (cx_q == XLAST) begin
          cx_d = '0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_BOX: begin
        if (box_last) begin
          state_d = S_IDLE;
          pix_d   = '0;
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bc_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bc_q    <= bc_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Outputs decode straight from registered state.
  always_comb begin
    oX         = '0;
    oY         = '0;
    oColour    = '0;
    oPlot      = 1'b0;
    oDone      = 2'b00;
    oClearDone = 1'b0;
    oBusy      = (state_q != S_IDLE);
    case (state_q)
      S_CLEAR: begin
        oX         = cx_q;
        oY         = cy_q;
        oPlot      = 1'b1;
        oClearDone = clr_last;
      end
      S_BOX: begin
        oX      = bpx;
        oY      = bpy;
        oColour = bc_q;
        oPlot   = (bpx < X_SCREEN_PIXELS) &&
                  (bpy < Y_SCREEN_PIXELS);
        if (box_last) begin
          oDone = owner_q ? 2'b10 : 2'b01;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed bench for vga_plot_arbiter.
// Table of single-client boxes plus tie, clear and reset sequences.
module tb_vga_plot_arbiter;

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic       iClear = 1'b0;
  logic [1:0] iReq = 2'b00;
  logic [7:0] iX0 = '0, iX1 = '0;
  logic [6:0] iY0 = '0, iY1 = '0;
  logic [2:0] iColour0 = '0, iColour1 = '0;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic [1:0] oDone;
  logic       oClearDone;
  logic       oBusy;

  int checks = 0;
  int errors = 0;

  vga_plot_arbiter dut (
    .iClock(iClock), .iReset(iReset), .iClear(iClear),
    .iReq(iReq), .iX0(iX0), .iX1(iX1), .iY0(iY0), .iY1(iY1),
    .iColour0(iColour0), .iColour1(iColour1),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .oDone(oDone), .oClearDone(oClearDone), .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic       cli;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         nplot;
    logic [7:0] lx;
    logic [6:0] ly;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    iClear = 1'b1;
    iReq   = 2'b11;
    step();
    iReset = 1'b0;
    iClear = 1'b0;
    iReq   = 2'b00;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, 32'(oBusy), 0);
    chk({nm, "_plot"}, 32'(oPlot), 0);
    chk({nm, "_done"}, 32'(oDone), 0);
    chk({nm, "_cdone"}, 32'(oClearDone), 0);
    chk({nm, "_x"}, 32'(oX), 0);
    chk({nm, "_y"}, 32'(oY), 0);
    chk({nm, "_col"}, 32'(oColour), 0);
  endtask

  task automatic wait_done(output logic [1:0] d);
    d = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (oDone != 2'b00) begin
        d = oDone;
        break;
      end
      step();
    end
  endtask

  task automatic do_box(input int k);
    int np;
    logic [7:0] ex;
    logic [6:0] ey;
    logic ep;
    logic [1:0] ed;
    iReq = vt[k].cli ? 2'b10 : 2'b01;
    if (vt[k].cli) begin
      iX1 = vt[k].x; iY1 = vt[k].y; iColour1 = vt[k].c;
    end else begin
      iX0 = vt[k].x; iY0 = vt[k].y; iColour0 = vt[k].c;
    end
    step();
    chk("grant_busy", 32'(oBusy), 1);
    // Inputs are free to move once granted.
    iX0 = 8'($urandom); iX1 = 8'($urandom);
    iY0 = 7'($urandom); iY1 = 7'($urandom);
    iColour0 = 3'($urandom); iColour1 = 3'($urandom);
    np = 0;
    for (int i = 0; i < 16; i++) begin
      ex = vt[k].x + 8'(i % 4);
      ey = vt[k].y + 7'(i / 4);
      ep = (ex < 8'd160) && (ey < 7'd120);
      ed = (i == 15) ? (vt[k].cli ? 2'b10 : 2'b01) : 2'b00;
      chk("box_x", 32'(oX), 32'(ex));
      chk("box_y", 32'(oY), 32'(ey));
      chk("box_col", 32'(oColour), 32'(vt[k].c));
      chk("box_plot", 32'(oPlot), 32'(ep));
      chk("box_done", 32'(oDone), 32'(ed));
      chk("box_busy", 32'(oBusy), 1);
      if (oPlot) np++;
      if (i == 15) begin
        chk("box_last_x", 32'(oX), 32'(vt[k].lx));
        chk("box_last_y", 32'(oY), 32'(vt[k].ly));
        iReq = 2'b00;
      end
      step();
    end
    chk("box_nplot", 32'(np), 32'(vt[k].nplot));
    chk_idle("after_box");
  endtask

  initial begin
    logic [1:0] d;
    int cnt;
    int bad;

    vt[0] = '{1'b0, 8'd10,  7'd20,  3'd5, 16, 8'd13,  7'd23};
    vt[1] = '{1'b1, 8'd158, 7'd118, 3'd7, 4,  8'd161, 7'd121};
    vt[2] = '{1'b0, 8'd254, 7'd126, 3'd3, 4,  8'd1,   7'd1};
    vt[3] = '{1'b1, 8'd0,   7'd0,   3'd1, 16, 8'd3,   7'd3};
    vt[4] = '{1'b0, 8'd156, 7'd116, 3'd2, 16, 8'd159, 7'd119};
    vt[5] = '{1'b1, 8'd159, 7'd10,  3'd6, 4,  8'd162, 7'd13};

    // Reset overrides held clear/requests.
    do_reset();
    chk_idle("reset");

    for (int k = 0; k < 6; k++) do_box(k);

    // Tie and round-robin.
    do_reset();
    iX0 = 8'd1;  iY0 = 7'd1;  iColour0 = 3'd1;
    iX1 = 8'd50; iY1 = 7'd50; iColour1 = 3'd2;
    iReq = 2'b11;
    step();
    chk("tie1_x", 32'(oX), 1);
    wait_done(d);
    chk("tie1_done", 32'(d), 32'(2'b01));
    chk("tie1_lx", 32'(oX), 4);
    iReq = 2'b10;
    step();
    chk("gap_busy", 32'(oBusy), 0);
    step();
    chk("tie2_busy", 32'(oBusy), 1);
    chk("tie2_x", 32'(oX), 50);
    wait_done(d);
    chk("tie2_done", 32'(d), 32'(2'b10));
    iReq = 2'b00;
    step();
    iReq = 2'b11;
    step();
    chk("tie3_x", 32'(oX), 1);
    wait_done(d);
    chk("tie3_done", 32'(d), 32'(2'b01));
    iReq = 2'b10;
    step();
    wait_done(d);
    chk("tie4_done", 32'(d), 32'(2'b10));
    iReq = 2'b00;
    step();

    // Clear has priority and sweeps the whole screen.
    do_reset();
    iX0 = 8'd7;  iY0 = 7'd8;  iColour0 = 3'd4;
    iX1 = 8'd99; iY1 = 7'd9;  iColour1 = 3'd5;
    iClear = 1'b1;
    iReq = 2'b11;
    step();
    iClear = 1'b0;
    chk("clr_busy", 32'(oBusy), 1);
    chk("clr_x0", 32'(oX), 0);
    chk("clr_y0", 32'(oY), 0);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      cnt++;
      if (oColour != 3'd0 || !oPlot || oDone != 2'b00) bad++;
      if (oClearDone) break;
      step();
    end
    chk("clr_len", 32'(cnt), 19200);
    chk("clr_bad", 32'(bad), 0);
    chk("clr_done", 32'(oClearDone), 1);
    chk("clr_lx", 32'(oX), 159);
    chk("clr_ly", 32'(oY), 119);
    step();
    chk("clr_idle", 32'(oBusy), 0);
    step();
    chk("clr_next_x", 32'(oX), 7);
    chk("clr_next_c", 32'(oColour), 4);
    iReq = 2'b00;

    // Reset in the middle of a box.
    do_reset();
    iX0 = 8'd10; iY0 = 7'd20; iColour0 = 3'd5;
    iReq = 2'b01;
    step();
    repeat (7) step();
    chk("mid_x", 32'(oX), 13);
    chk("mid_y", 32'(oY), 21);
    iReset = 1'b1;
    iReq = 2'b10;
    iX1 = 8'd40; iY1 = 7'd30; iColour1 = 3'd4;
    step();
    chk_idle("mid_rst");
    iReset = 1'b0;
    step();
    chk("mid_grant", 32'(oBusy), 1);
    chk("mid_grant_x", 32'(oX), 40);
    wait_done(d);
    chk("mid_done", 32'(d), 32'(2'b10));
    iReq = 2'b00;
    step();
    chk_idle("end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
